// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-to-RAM bridge: FSM encoding,
// latency counter width and RAM operation encoding.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    I_WAIT,
    I_RSP,
    D_WR,
    D_RD,
    D_WAIT,
    D_RSP
  } state_t;

  localparam int         LAT_W       = 3;
  localparam logic [3:0] RAM_WE_READ = 4'b0000;

  // WAIT spans READ_LAT-1 cycles; the counter terminates on zero, so it loads READ_LAT-2.
  function automatic logic [LAT_W-1:0] lat_load(input int read_lat);
    return (read_lat > 1) ? LAT_W'(read_lat - 2) : '0;
  endfunction

endpackage

// File: rtl/mem_txn_counter.sv
// 32-bit wrapping transaction counter with increment enable.
module mem_txn_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (inc) count <= count + 32'd1;
  end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Serves the CPU instruction and data channels from one single-port word RAM,
// arbitrating (data first), sequencing read latency and holding responses until acked.
//
// state  | meaning
// IDLE   | accepting requests; data channel has priority
// I_RD   | instruction read strobe to RAM
// I_WAIT | waiting out remaining RAM read latency (fetch)
// I_RSP  | Instruction valid, waiting for Inst_Ack
// D_WR   | store write strobe to RAM
// D_RD   | load read strobe to RAM
// D_WAIT | waiting out remaining RAM read latency (load)
// D_RSP  | Read_data valid, waiting for Read_data_Ack
module cpu_mem_bridge
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC,
  input  logic              Inst_Req_Valid,
  output logic              Inst_Req_Ack,
  output logic [31:0]       Instruction,
  output logic              Inst_Valid,
  input  logic              Inst_Ack,
  input  logic [31:0]       Address,
  input  logic              MemWrite,
  input  logic [31:0]       Write_data,
  input  logic [3:0]        Write_strb,
  input  logic              MemRead,
  output logic              Mem_Req_Ack,
  output logic [31:0]       Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ack,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       cnt_ifetch,
  output logic [31:0]       cnt_load,
  output logic [31:0]       cnt_store
);

  localparam logic [LAT_W-1:0] LAT_LOAD = lat_load(READ_LAT);

  state_t            state, next_state;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [LAT_W-1:0]  lat_q;
  logic [31:0]       rsp_q;
  logic              fresh_q;
  logic [31:0]       rsp_word;
  logic              take_data, take_inst;
  logic              inc_ifetch, inc_load, inc_store;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{PC[31:ADDR_W], PC[1:0], Address[31:ADDR_W], Address[1:0]};

  always_comb begin
    next_state   = state;
    Inst_Req_Ack = 1'b0;
    Mem_Req_Ack  = 1'b0;
    ram_en       = 1'b0;
    ram_we       = RAM_WE_READ;
    ram_wdata    = '0;
    take_data    = 1'b0;
    take_inst    = 1'b0;
    inc_ifetch   = 1'b0;
    inc_load     = 1'b0;
    inc_store    = 1'b0;
    case (state)
      IDLE: begin
        if (MemRead || MemWrite) begin
          Mem_Req_Ack = 1'b1;
          take_data   = 1'b1;
          next_state  = MemWrite ? D_WR : D_RD;
        end else if (Inst_Req_Valid) begin
          Inst_Req_Ack = 1'b1;
          take_inst    = 1'b1;
          next_state   = I_RD;
        end
      end
      I_RD: begin
        ram_en     = 1'b1;
        next_state = (READ_LAT == 1) ? I_RSP : I_WAIT;
      end
      I_WAIT: if (lat_q == '0) next_state = I_RSP;
      I_RSP: begin
        if (Inst_Ack) begin
          next_state = IDLE;
          inc_ifetch = 1'b1;
        end
      end
      D_WR: begin
        ram_en     = 1'b1;
        ram_we     = strb_q;
        ram_wdata  = wdata_q;
        next_state = IDLE;
        inc_store  = 1'b1;
      end
      D_RD: begin
        ram_en     = 1'b1;
        next_state = (READ_LAT == 1) ? D_RSP : D_WAIT;
      end
      D_WAIT: if (lat_q == '0) next_state = D_RSP;
      D_RSP: begin
        if (Read_data_Ack) begin
          next_state = IDLE;
          inc_load   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      lat_q   <= '0;
      rsp_q   <= '0;
      fresh_q <= 1'b0;
    end else begin
      state <= next_state;
      if (take_data) begin
        addr_q  <= Address[ADDR_W-1:2];
        wdata_q <= Write_data;
        strb_q  <= Write_strb;
      end else if (take_inst) begin
        addr_q <= PC[ADDR_W-1:2];
      end
      if (state == I_RD || state == D_RD)
        lat_q <= LAT_LOAD;
      else if ((state == I_WAIT || state == D_WAIT) && lat_q != '0)
        lat_q <= lat_q - 1'b1;
      fresh_q <= (next_state == I_RSP && state != I_RSP) ||
                 (next_state == D_RSP && state != D_RSP);
      if (fresh_q) rsp_q <= ram_rdata;
    end
  end

  // RAM data is only guaranteed on the first response cycle; pass it through, then hold the copy.
  assign rsp_word        = fresh_q ? ram_rdata : rsp_q;
  assign Inst_Valid      = (state == I_RSP);
  assign Read_data_Valid = (state == D_RSP);
  assign Instruction     = Inst_Valid      ? rsp_word : rsp_q;
  assign Read_data       = Read_data_Valid ? rsp_word : rsp_q;
  assign ram_addr        = addr_q;

  mem_txn_counter u_cnt_ifetch (.clk(clk), .rst(rst), .inc(inc_ifetch), .count(cnt_ifetch));
  mem_txn_counter u_cnt_load   (.clk(clk), .rst(rst), .inc(inc_load),   .count(cnt_load));
  mem_txn_counter u_cnt_store  (.clk(clk), .rst(rst), .inc(inc_store),  .count(cnt_store));

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: instance 0 uses READ_LAT=1, instance 1 READ_LAT=3,
// each backed by its own RAM model whose read data is only valid for one cycle.
module tb_cpu_mem_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] pc [2], address [2], write_data [2], instruction [2], read_data [2];
  logic [31:0] ram_wdata [2], ram_rdata [2], cnt_ifetch [2], cnt_load [2], cnt_store [2];
  logic        inst_req_valid [2], inst_req_ack [2], inst_valid [2], inst_ack [2];
  logic        mem_write [2], mem_read [2], mem_req_ack [2], read_data_valid [2];
  logic        read_data_ack [2], ram_en [2];
  logic [3:0]  write_strb [2], ram_we [2];
  logic [13:0] ram_addr [2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] init_word(input logic [15:0] i);
    return (i == 16'd4) ? 32'h0050_0093 : {16'hC0DE, i};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [16384];
    logic [7:0]  vld = '0;
    logic [31:0] dp [8];

    cpu_mem_bridge #(.ADDR_W(16), .READ_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .PC(pc[g]), .Inst_Req_Valid(inst_req_valid[g]), .Inst_Req_Ack(inst_req_ack[g]),
      .Instruction(instruction[g]), .Inst_Valid(inst_valid[g]), .Inst_Ack(inst_ack[g]),
      .Address(address[g]), .MemWrite(mem_write[g]), .Write_data(write_data[g]),
      .Write_strb(write_strb[g]), .MemRead(mem_read[g]), .Mem_Req_Ack(mem_req_ack[g]),
      .Read_data(read_data[g]), .Read_data_Valid(read_data_valid[g]),
      .Read_data_Ack(read_data_ack[g]),
      .ram_en(ram_en[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g]),
      .cnt_ifetch(cnt_ifetch[g]), .cnt_load(cnt_load[g]), .cnt_store(cnt_store[g])
    );

    always @(posedge clk) begin
      vld   <= {vld[6:0], ram_en[g] && ram_we[g] == 4'b0000};
      dp[0] <= mem[ram_addr[g]];
      for (int i = 1; i < 8; i++) dp[i] <= dp[i-1];
      if (rst) begin
        for (int i = 0; i < 16384; i++) mem[i] = init_word(16'(i));
      end else if (ram_en[g] && ram_we[g] != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[g][b]) mem[ram_addr[g]][b*8 +: 8] = ram_wdata[g][b*8 +: 8];
      end
    end

    assign ram_rdata[g] = vld[LAT-1] ? dp[LAT-1] : 32'hDEAD_BEEF;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs(input int d);
    pc[d] = '0; inst_req_valid[d] = 1'b0; inst_ack[d] = 1'b0;
    address[d] = '0; mem_write[d] = 1'b0; write_data[d] = '0; write_strb[d] = '0;
    mem_read[d] = 1'b0; read_data_ack[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs(0);
    idle_inputs(1);
    repeat (3) @(posedge clk);
    mid();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({inst_req_ack[d], inst_valid[d], mem_req_ack[d], read_data_valid[d], ram_en[d], ram_we[d]} !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got %b want 0", d,
                 {inst_req_ack[d], inst_valid[d], mem_req_ack[d], read_data_valid[d], ram_en[d], ram_we[d]});
      end
      n_tests++;
      if ({cnt_ifetch[d], cnt_load[d], cnt_store[d], instruction[d], read_data[d]} !== 160'd0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: counters/data not zero (%h %h %h %h %h)", d,
                 cnt_ifetch[d], cnt_load[d], cnt_store[d], instruction[d], read_data[d]);
      end
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    cyc();
    pc[0] = 32'h10; inst_req_valid[0] = 1'b1;
    mid();
    n_tests++;
    if ({inst_req_ack[0], mem_req_ack[0]} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_ack: got %b want 10", {inst_req_ack[0], mem_req_ack[0]});
    end
    cyc();
    inst_req_valid[0] = 1'b0;
    mid();
    n_tests++;
    if ({ram_en[0], ram_we[0], ram_addr[0], inst_valid[0]} !== {1'b1, 4'b0000, 14'd4, 1'b0}) begin
      n_fail++; $display("FAIL fetch_ram: en=%b we=%b addr=%h valid=%b want 1 0000 0004 0",
                         ram_en[0], ram_we[0], ram_addr[0], inst_valid[0]);
    end
    cyc();
    mid();
    n_tests++;
    if (inst_valid[0] !== 1'b1 || instruction[0] !== 32'h0050_0093) begin
      n_fail++; $display("FAIL fetch_rsp: valid=%b data=%h want 1 00500093", inst_valid[0], instruction[0]);
    end
    inst_ack[0] = 1'b1;
    cyc();
    inst_ack[0] = 1'b0;
    mid();
    n_tests++;
    if (inst_valid[0] !== 1'b0 || cnt_ifetch[0] !== 32'd1) begin
      n_fail++; $display("FAIL fetch_done: valid=%b cnt=%0d want 0 1", inst_valid[0], cnt_ifetch[0]);
    end
  endtask

  task automatic test_store();
    cyc();
    address[0] = 32'h22; write_data[0] = 32'h00AB_0000; write_strb[0] = 4'b0100;
    mem_write[0] = 1'b1; inst_req_valid[0] = 1'b1; pc[0] = 32'h10;
    mid();
    n_tests++;
    if ({mem_req_ack[0], inst_req_ack[0]} !== 2'b10) begin
      n_fail++; $display("FAIL store_ack: got %b want 10", {mem_req_ack[0], inst_req_ack[0]});
    end
    cyc();
    mem_write[0] = 1'b0;
    mid();
    n_tests++;
    if ({ram_en[0], ram_we[0], ram_addr[0], ram_wdata[0], inst_req_ack[0]} !==
        {1'b1, 4'b0100, 14'd8, 32'h00AB_0000, 1'b0}) begin
      n_fail++; $display("FAIL store_ram: en=%b we=%b addr=%h wdata=%h iack=%b want 1 0100 0008 00ab0000 0",
                         ram_en[0], ram_we[0], ram_addr[0], ram_wdata[0], inst_req_ack[0]);
    end
    inst_req_valid[0] = 1'b0;
    cyc();
    mid();
    n_tests++;
    if (ram_en[0] !== 1'b0 || cnt_store[0] !== 32'd1) begin
      n_fail++; $display("FAIL store_done: en=%b cnt=%0d want 0 1", ram_en[0], cnt_store[0]);
    end
  endtask

  task automatic test_arb();
    cyc();
    address[0] = 32'h20; mem_read[0] = 1'b1; pc[0] = 32'h10; inst_req_valid[0] = 1'b1;
    mid();
    n_tests++;
    if ({mem_req_ack[0], inst_req_ack[0]} !== 2'b10) begin
      n_fail++; $display("FAIL arb_ack: got %b want 10", {mem_req_ack[0], inst_req_ack[0]});
    end
    cyc();
    mem_read[0] = 1'b0;
    mid();
    n_tests++;
    if ({ram_en[0], ram_addr[0], inst_req_ack[0]} !== {1'b1, 14'd8, 1'b0}) begin
      n_fail++; $display("FAIL arb_ram: en=%b addr=%h iack=%b want 1 0008 0", ram_en[0], ram_addr[0], inst_req_ack[0]);
    end
    cyc();
    mid();
    n_tests++;
    if ({read_data_valid[0], read_data[0], inst_req_ack[0]} !== {1'b1, 32'hC0AB_0008, 1'b0}) begin
      n_fail++; $display("FAIL arb_load: valid=%b data=%h iack=%b want 1 c0ab0008 0",
                         read_data_valid[0], read_data[0], inst_req_ack[0]);
    end
    read_data_ack[0] = 1'b1;
    cyc();
    read_data_ack[0] = 1'b0;
    mid();
    n_tests++;
    if ({inst_req_ack[0], read_data_valid[0]} !== 2'b10 || cnt_load[0] !== 32'd1) begin
      n_fail++; $display("FAIL arb_next: iack=%b valid=%b cnt_load=%0d want 1 0 1",
                         inst_req_ack[0], read_data_valid[0], cnt_load[0]);
    end
    cyc();
    inst_req_valid[0] = 1'b0;
    mid();
    cyc();
    mid();
    n_tests++;
    if (inst_valid[0] !== 1'b1 || instruction[0] !== 32'h0050_0093) begin
      n_fail++; $display("FAIL arb_fetch: valid=%b data=%h want 1 00500093", inst_valid[0], instruction[0]);
    end
    inst_ack[0] = 1'b1;
    cyc();
    inst_ack[0] = 1'b0;
    mid();
    n_tests++;
    if (cnt_ifetch[0] !== 32'd2) begin
      n_fail++; $display("FAIL arb_cnt: cnt_ifetch=%0d want 2", cnt_ifetch[0]);
    end
  endtask

  task automatic test_hold();
    cyc();
    read_data_ack[1] = 1'b1; inst_ack[1] = 1'b1;
    cyc();
    read_data_ack[1] = 1'b0; inst_ack[1] = 1'b0;
    address[1] = 32'hFFFF_FFFC; mem_read[1] = 1'b1;
    mid();
    n_tests++;
    if ({cnt_load[1], cnt_ifetch[1]} !== 64'd0 || mem_req_ack[1] !== 1'b1) begin
      n_fail++; $display("FAIL stray_ack: load=%0d ifetch=%0d mack=%b want 0 0 1",
                         cnt_load[1], cnt_ifetch[1], mem_req_ack[1]);
    end
    cyc();
    mem_read[1] = 1'b0;
    mid();
    n_tests++;
    if ({ram_en[1], ram_addr[1]} !== {1'b1, 14'h3FFF}) begin
      n_fail++; $display("FAIL addr_wrap: en=%b addr=%h want 1 3fff", ram_en[1], ram_addr[1]);
    end
    for (int k = 2; k < 4; k++) begin
      cyc();
      mid();
      n_tests++;
      if (read_data_valid[1] !== 1'b0) begin
        n_fail++; $display("FAIL lat3_early T+%0d: valid=%b want 0", k, read_data_valid[1]);
      end
    end
    for (int k = 4; k < 9; k++) begin
      cyc();
      mid();
      n_tests++;
      if (read_data_valid[1] !== 1'b1 || read_data[1] !== 32'hC0DE_3FFF) begin
        n_fail++; $display("FAIL lat3_hold T+%0d: valid=%b data=%h want 1 c0de3fff", k, read_data_valid[1], read_data[1]);
      end
    end
    read_data_ack[1] = 1'b1;
    cyc();
    read_data_ack[1] = 1'b0;
    mid();
    n_tests++;
    if (read_data_valid[1] !== 1'b0 || cnt_load[1] !== 32'd1) begin
      n_fail++; $display("FAIL lat3_done: valid=%b cnt=%0d want 0 1", read_data_valid[1], cnt_load[1]);
    end
  endtask

  task automatic test_rst_wait();
    cyc();
    address[1] = 32'h10; mem_read[1] = 1'b1;
    cyc();
    mem_read[1] = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({read_data_valid[1], cnt_load[1], cnt_ifetch[0], cnt_store[0]} !== 97'd0) begin
      n_fail++; $display("FAIL rst_async: valid=%b load1=%0d ifetch0=%0d store0=%0d want 0",
                         read_data_valid[1], cnt_load[1], cnt_ifetch[0], cnt_store[0]);
    end
    #2;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      n_tests++;
      if (read_data_valid[1] !== 1'b0 || ram_en[1] !== 1'b0) begin
        n_fail++; $display("FAIL rst_discard %0d: valid=%b en=%b want 0 0", k, read_data_valid[1], ram_en[1]);
      end
      cyc();
    end
    pc[1] = 32'h10; inst_req_valid[1] = 1'b1;
    mid();
    n_tests++;
    if (inst_req_ack[1] !== 1'b1) begin
      n_fail++; $display("FAIL rst_refetch_ack: got %b want 1", inst_req_ack[1]);
    end
    cyc();
    inst_req_valid[1] = 1'b0;
    repeat (3) cyc();
    mid();
    n_tests++;
    if (inst_valid[1] !== 1'b1 || instruction[1] !== 32'h0050_0093) begin
      n_fail++; $display("FAIL rst_refetch: valid=%b data=%h want 1 00500093", inst_valid[1], instruction[1]);
    end
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (inst_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL rst_drop_valid: got %b want 0", inst_valid[1]);
    end
    #1;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_store_variants();
    cyc();
    address[0] = 32'h40; write_data[0] = 32'h1234_5678; write_strb[0] = 4'b0000; mem_write[0] = 1'b1;
    mid();
    n_tests++;
    if (mem_req_ack[0] !== 1'b1) begin
      n_fail++; $display("FAIL strb0_ack: got %b want 1", mem_req_ack[0]);
    end
    cyc();
    mem_write[0] = 1'b1; mem_read[0] = 1'b1; write_strb[0] = 4'b1111;
    mid();
    n_tests++;
    if ({ram_en[0], ram_we[0], mem_req_ack[0]} !== {1'b1, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL strb0_ram: en=%b we=%b mack=%b want 1 0000 0", ram_en[0], ram_we[0], mem_req_ack[0]);
    end
    cyc();
    mid();
    n_tests++;
    if ({mem_req_ack[0], cnt_store[0]} !== {1'b1, 32'd1}) begin
      n_fail++; $display("FAIL strb0_cnt: mack=%b cnt=%0d want 1 1", mem_req_ack[0], cnt_store[0]);
    end
    cyc();
    mem_write[0] = 1'b0; mem_read[0] = 1'b0;
    mid();
    n_tests++;
    if ({ram_en[0], ram_we[0], ram_wdata[0]} !== {1'b1, 4'b1111, 32'h1234_5678}) begin
      n_fail++; $display("FAIL rw_as_store: en=%b we=%b wdata=%h want 1 1111 12345678",
                         ram_en[0], ram_we[0], ram_wdata[0]);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      mid();
      n_tests++;
      if (read_data_valid[0] !== 1'b0) begin
        n_fail++; $display("FAIL rw_no_read %0d: valid=%b want 0", k, read_data_valid[0]);
      end
    end
    n_tests++;
    if ({cnt_store[0], cnt_load[0]} !== {32'd2, 32'd0}) begin
      n_fail++; $display("FAIL rw_cnt: store=%0d load=%0d want 2 0", cnt_store[0], cnt_load[0]);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_arb();
    test_hold();
    test_rst_wait();
    test_store_variants();
    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
